// File: rtl/tm1638_pkg.sv
// Shared TM1638 constants: bus command bytes, reader state encoding and key decode helper.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_WRITE_AUTO  = 8'h40;
  localparam logic [7:0] CMD_DATA_WRITE_FIXED = 8'h44;
  localparam logic [7:0] CMD_READ_KEYS        = 8'h42;
  localparam logic [7:0] CMD_ADDR_BASE        = 8'hC0;
  localparam logic [7:0] CMD_DISPLAY_ON       = 8'h88;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned READ_BITS = 32;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] StIdle  = 3'd0;
  localparam logic [STATE_W-1:0] StSetup = 3'd1;
  localparam logic [STATE_W-1:0] StCmd   = 3'd2;
  localparam logic [STATE_W-1:0] StWait  = 3'd3;
  localparam logic [STATE_W-1:0] StRead  = 3'd4;

  // Each scan byte carries two keys, on bits 0 and 4.
  function automatic logic [7:0] decode_keys(input logic [READ_BITS-1:0] raw);
    logic [7:0] keys;
    keys = '0;
    for (int j = 0; j < 4; j++) begin
      keys[j]   = raw[8*j];
      keys[j+4] = raw[8*j+4];
    end
    return keys;
  endfunction

endpackage

// File: rtl/tm1638_key_reader_if.sv
// Request/result handshake and TM1638 pad signals of the key reader.
interface tm1638_key_reader_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        changed;
  logic [7:0]  keys;
  logic [31:0] raw;
  logic        tm_stb;
  logic        tm_clk;
  logic        dio_out;
  logic        dio_oe;
  logic        dio_in;

  modport slave (
    input  start, dio_in,
    output busy, done, changed, keys, raw, tm_stb, tm_clk, dio_out, dio_oe
  );

  modport master (
    output start, dio_in,
    input  busy, done, changed, keys, raw, tm_stb, tm_clk, dio_out, dio_oe
  );
endinterface

// File: rtl/tm1638_half_tick.sv
// One-cycle pulse every CLK_DIV enabled cycles; marks a serial half-period boundary.
module tm1638_half_tick #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CntMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key scan: sends the read-keys command, clocks in four scan bytes, publishes keys.
module tm1638_key_reader #(
  parameter int unsigned CLK_DIV   = 25,
  parameter int unsigned WAIT_HALF = 2
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  tm1638_key_reader_if.slave   bus
);

  import tm1638_pkg::*;

  localparam int unsigned WaitW = $clog2(WAIT_HALF + 1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 changed_q, changed_d;
  logic [7:0]           keys_q, keys_d;
  logic [READ_BITS-1:0] raw_q, raw_d;
  logic [READ_BITS-1:0] shift_q, shift_d;
  logic                 stb_q, stb_d;
  logic                 sclk_q, sclk_d;
  logic                 oe_q, oe_d;
  logic                 dout_q, dout_d;
  logic [5:0]           bit_q, bit_d;
  logic [WaitW-1:0]     wait_q, wait_d;

  logic accept;
  logic tick;
  logic [7:0] new_keys;

  assign accept   = (state_q == StIdle) && bus.start;
  assign new_keys = decode_keys(shift_q);

  tm1638_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk_i  (clk_50M),
    .rst_ni (rst_n),
    .en_i   (busy_q),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    changed_d = changed_q;
    keys_d    = keys_q;
    raw_d     = raw_q;
    shift_d   = shift_q;
    stb_d     = stb_q;
    sclk_d    = sclk_q;
    oe_d      = oe_q;
    dout_d    = dout_q;
    bit_d     = bit_q;
    wait_d    = wait_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSetup;
          busy_d  = 1'b1;
          stb_d   = 1'b0;
          oe_d    = 1'b1;
          dout_d  = 1'b1;
          sclk_d  = 1'b1;
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StCmd;
          sclk_d  = 1'b0;
          dout_d  = CMD_READ_KEYS[0];
          bit_d   = '0;
        end
      end
      StCmd: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 6'(CMD_BITS - 1)) begin
            // Hand DIO to the chip for the Twait gap and the scan bytes.
            state_d = StWait;
            oe_d    = 1'b0;
            dout_d  = 1'b1;
            wait_d  = WaitW'(1);
          end else begin
            bit_d  = bit_q + 6'd1;
            sclk_d = 1'b0;
            dout_d = CMD_READ_KEYS[bit_q[2:0] + 3'd1];
          end
        end
      end
      StWait: begin
        if (tick) begin
          if (wait_q == WaitW'(WAIT_HALF)) begin
            state_d = StRead;
            sclk_d  = 1'b0;
            bit_d   = '0;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
      end
      StRead: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = {bus.dio_in, shift_q[READ_BITS-1:1]};
            bit_d   = bit_q + 6'd1;
          end else if (bit_q == 6'(READ_BITS)) begin
            state_d   = StIdle;
            stb_d     = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            raw_d     = shift_q;
            keys_d    = new_keys;
            changed_d = (new_keys != keys_q);
          end else begin
            sclk_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      keys_q    <= '0;
      raw_q     <= '0;
      shift_q   <= '0;
      stb_q     <= 1'b1;
      sclk_q    <= 1'b1;
      oe_q      <= 1'b0;
      dout_q    <= 1'b1;
      bit_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      changed_q <= changed_d;
      keys_q    <= keys_d;
      raw_q     <= raw_d;
      shift_q   <= shift_d;
      stb_q     <= stb_d;
      sclk_q    <= sclk_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      bit_q     <= bit_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.changed = changed_q;
  assign bus.keys    = keys_q;
  assign bus.raw     = raw_q;
  assign bus.tm_stb  = stb_q;
  assign bus.tm_clk  = sclk_q;
  assign bus.dio_out = dout_q;
  assign bus.dio_oe  = oe_q;

endmodule
